// File: rtl/qpsk_tx_pkg.sv
// qpsk_tx_pkg: state codes, PRBS9 constants and filter-facing
// defaults shared by the QPSK tx controller and the tx filters.
package qpsk_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_RUN      = 2'd2,
    ST_FLUSH    = 2'd3
  } tx_state_e;

  // Samples per symbol and filter span, shared with the rrc filters.
  localparam int OS_DEF     = 4;
  localparam int NBAUDS_DEF = 6;

  // x^9 + x^5 + 1: feedback from register bits 8 and 4.
  localparam logic [8:0] PRBS9_TAPS   = 9'h110;
  localparam logic [8:0] PRBS9_SEED_I = 9'h1AA;
  localparam logic [8:0] PRBS9_SEED_Q = 9'h1FE;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prbs9_gen.sv
// prbs9_gen: 9-bit Fibonacci LFSR (x^9+x^5+1) with reseed.
// Ports: clk, rst (async, low), i_load (reseed), i_adv (step),
//        o_bit (current output bit, register MSB).
module prbs9_gen
  import qpsk_tx_pkg::*;
#(
  parameter logic [8:0] SEED = PRBS9_SEED_I
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_adv,
  output logic o_bit
);

  logic [8:0] r_lfsr;
  logic       w_fb;

  assign w_fb  = ^(r_lfsr & PRBS9_TAPS);
  assign o_bit = r_lfsr[8];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= SEED;
    end else if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_adv) begin
      r_lfsr <= {r_lfsr[7:0], w_fb};
    end
  end

endmodule

// File: rtl/qpsk_tx_ctrl.sv
// qpsk_tx_ctrl: symbol-rate sequencer for the QPSK I/Q tx filters.
// Frames bursts as preamble / data / flush tail, drives the sample
// phase and symbol strobe, and counts upstream underflows.
// Ports: clk, rst (async, low); i_enable burst request;
//   i_sym_data/i_sym_valid/o_sym_ready upstream symbols;
//   o_tx_i/o_tx_q rail bits; o_sym_stb, o_phase filter timing;
//   o_state, o_busy, o_underflow_cnt status.
// Option: define QPSK_TX_PRBS_EN to add i_prbs_mode, which
//   replaces RUN data with two PRBS9 streams.
module qpsk_tx_ctrl
  import qpsk_tx_pkg::*;
#(
  parameter int OS           = OS_DEF,
  parameter int NBAUDS       = NBAUDS_DEF,
  parameter int PREAMBLE_LEN = 16,
  parameter int UFL_W        = 16,
  localparam int PH_W        = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_enable,
  input  logic [1:0]       i_sym_data,
  input  logic             i_sym_valid,
`ifdef QPSK_TX_PRBS_EN
  input  logic             i_prbs_mode,
`endif
  output logic             o_sym_ready,
  output logic             o_tx_i,
  output logic             o_tx_q,
  output logic             o_sym_stb,
  output logic [PH_W-1:0]  o_phase,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic [UFL_W-1:0] o_underflow_cnt
);

  localparam int CNT_W =
    $clog2(imax(PREAMBLE_LEN, NBAUDS) + 1);

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OS - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] FL_LAST  = CNT_W'(NBAUDS - 1);

  tx_state_e        r_state, w_state_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [UFL_W-1:0] r_ufl, w_ufl_nxt;
  logic             r_tx_i, w_tx_i_nxt;
  logic             r_tx_q, w_tx_q_nxt;
  logic             r_tog, w_tog_nxt;

  logic w_busy;
  logic w_stb;
  logic w_prbs_mode;
  logic w_prbs_i;
  logic w_prbs_q;

  assign w_busy = (r_state != ST_IDLE);
  assign w_stb  = w_busy && (r_phase == PH_LAST);

`ifdef QPSK_TX_PRBS_EN
  logic w_prbs_load;
  logic w_prbs_adv;

  assign w_prbs_mode = i_prbs_mode;
  assign w_prbs_load = (r_state != ST_RUN) &&
                       (w_state_nxt == ST_RUN);
  assign w_prbs_adv  = (r_state == ST_RUN) && w_stb;

  prbs9_gen #(
    .SEED(PRBS9_SEED_I)
  ) u_prbs_i (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_prbs_load),
    .i_adv (w_prbs_adv),
    .o_bit (w_prbs_i)
  );

  prbs9_gen #(
    .SEED(PRBS9_SEED_Q)
  ) u_prbs_q (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_prbs_load),
    .i_adv (w_prbs_adv),
    .o_bit (w_prbs_q)
  );
`else
  assign w_prbs_mode = 1'b0;
  assign w_prbs_i    = 1'b0;
  assign w_prbs_q    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_phase <= '0;
      r_cnt   <= '0;
      r_ufl   <= '0;
      r_tx_i  <= 1'b0;
      r_tx_q  <= 1'b0;
      r_tog   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ufl   <= w_ufl_nxt;
      r_tx_i  <= w_tx_i_nxt;
      r_tx_q  <= w_tx_q_nxt;
      r_tog   <= w_tog_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = w_busy ? r_phase + PH_W'(1) : '0;
    w_cnt_nxt   = r_cnt;
    w_ufl_nxt   = r_ufl;
    w_tx_i_nxt  = r_tx_i;
    w_tx_q_nxt  = r_tx_q;
    w_tog_nxt   = r_tog;

    unique case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_PREAMBLE;
          w_cnt_nxt   = '0;
        end
      end

      ST_PREAMBLE: begin
        if (w_stb) begin
          w_tx_i_nxt = r_tog;
          w_tx_q_nxt = r_tog;
          w_tog_nxt  = ~r_tog;
          if (!i_enable) begin
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = '0;
          end else if (r_cnt == PRE_LAST) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      ST_RUN: begin
        if (w_stb) begin
          if (!i_enable) begin
            w_tx_i_nxt  = r_tog;
            w_tx_q_nxt  = r_tog;
            w_tog_nxt   = ~r_tog;
            w_state_nxt = ST_FLUSH;
            w_cnt_nxt   = '0;
          end else if (w_prbs_mode) begin
            w_tx_i_nxt = w_prbs_i;
            w_tx_q_nxt = w_prbs_q;
          end else if (i_sym_valid) begin
            w_tx_i_nxt = i_sym_data[1];
            w_tx_q_nxt = i_sym_data[0];
          end else begin
            // Underflow: keep the line busy with idle symbols.
            w_tx_i_nxt = r_tog;
            w_tx_q_nxt = r_tog;
            w_tog_nxt  = ~r_tog;
            if (r_ufl != '1) begin
              w_ufl_nxt = r_ufl + UFL_W'(1);
            end
          end
        end
      end

      ST_FLUSH: begin
        if (w_stb) begin
          w_tx_i_nxt = r_tog;
          w_tx_q_nxt = r_tog;
          w_tog_nxt  = ~r_tog;
          if (r_cnt == FL_LAST) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_sym_ready = (r_state == ST_RUN) && w_stb &&
                       i_enable && !w_prbs_mode;
  assign o_tx_i          = r_tx_i;
  assign o_tx_q          = r_tx_q;
  assign o_sym_stb       = w_stb;
  assign o_phase         = r_phase;
  assign o_state         = r_state;
  assign o_busy          = w_busy;
  assign o_underflow_cnt = r_ufl;

endmodule

// File: doc/qpsk_tx_ctrl.md
Name: qpsk_tx_ctrl

Overview:
- Symbol-rate sequencer in front of the two per-rail raised-cosine tx filters (I and Q) of the QPSK transmitter.
- Generates the oversampling phase and the symbol strobe for the filters.
- Accepts 2-bit symbols from upstream via valid/ready, splits them onto the I/Q bit lines and frames each burst with a preamble and a filter-flush tail.
- Tracks upstream underflow.

Parameters:
- OS, 4: samples per symbol; phase counter modulus (power of 2, ≥2).
- NBAUDS, 6: filter span in symbols; flush length.
- PREAMBLE_LEN, 16: preamble symbols per burst (≥1).
- UFL_W, 16: underflow counter width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active low
- i_enable  in  1  level; burst request
- i_sym_data  in  2  [1]=I bit, [0]=Q bit
- i_sym_valid  in  1  upstream symbol valid
- o_sym_ready  out  1  symbol consumed this cycle
- o_tx_i  out  1  bit to I-rail filter
- o_tx_q  out  1  bit to Q-rail filter
- o_sym_stb  out  1  high for the last phase of each symbol period
- o_phase  out  log2(OS)  sample phase to filters
- o_state  out  2  IDLE=0, PREAMBLE=1, RUN=2, FLUSH=3
- o_busy  out  1  state != IDLE
- o_underflow_cnt  out  UFL_W  saturating underflow count

Behaviour:
- Reset (rst low, async): state IDLE, phase 0, o_tx_i=o_tx_q=0, preamble toggle=1, symbol counter 0, o_underflow_cnt 0. All outputs registered or derived combinationally from registers.
- Phase counter:
  - Holds 0 in IDLE.
  - Otherwise increments mod OS each clk.
  - o_sym_stb = busy && phase==OS-1 (combinational).
- Symbol update:
  - o_tx_i/o_tx_q change only on the clk edge where o_sym_stb=1, i.e. a new symbol appears together with phase 0. Latency from accepted symbol to o_tx: 1 clk.
- o_sym_ready = (state==RUN) && o_sym_stb && i_enable. Combinational, single-cycle. Symbol transferred when ready && valid.
- IDLE:
  - i_enable=1 → PREAMBLE next clk, phase starts at 0.
  - Outputs held at their last values.
- PREAMBLE:
  - Each strobe drives I=Q=toggle, then inverts toggle.
  - Counts strobes; after PREAMBLE_LEN strobes → RUN.
  - If i_enable=0 at any strobe → FLUSH (preamble aborted; that strobe still emits a preamble symbol).
- RUN, at each strobe:
  - i_enable=0 → FLUSH; no symbol consumed; emit alternating idle symbol.
  - else valid=1 → drive i_sym_data.
  - else (underflow) → emit alternating idle symbol (toggle continues) and increment o_underflow_cnt, saturating at all-ones.
- FLUSH:
  - Emits NBAUDS alternating symbols, one per strobe, so the filter delay line drains.
  - After the NBAUDS-th strobe → IDLE.
  - i_enable ignored until IDLE is reached; re-entry to PREAMBLE no earlier than the clk after entering IDLE.
- Between strobes, i_enable and i_sym_valid are don't-care.
- Symbol counter width: clog2(max(PREAMBLE_LEN, NBAUDS)+1). Cleared on every state change.
- o_underflow_cnt clears only on reset.
- Reset mid-burst: immediate return to the reset values above; no flush is emitted.

Optional Feature:
- Macro: QPSK_TX_PRBS_EN.
- Defined:
  - Adds input port i_prbs_mode (1 bit).
  - When i_prbs_mode=1 in RUN, the I bit comes from PRBS9 generator (x^9+x^5+1, seed 9'h1AA) and the Q bit from a second PRBS9 generator (seed 9'h1FE). Each generator advances once per RUN strobe.
  - i_sym_valid ignored, o_sym_ready held 0, no underflow counting.
  - Both generators reseed on reset and on entry to RUN.
- Undefined: port absent; RUN always uses i_sym_data.

Decomposition:
- Package qpsk_tx_pkg holds:
  - state encoding constants (ST_IDLE..ST_FLUSH);
  - PRBS9 polynomial taps and both seeds;
  - defaults for OS and NBAUDS, shared with the tx filter.
- Sub-module prbs9_gen: 9-bit LFSR with seed parameter, load and advance inputs, 1-bit output. Instantiated twice, only under QPSK_TX_PRBS_EN.

Test Plan:
- Reset then i_enable=1 with OS=4, PREAMBLE_LEN=16 → o_phase cycles 0,1,2,3. o_tx_i/q show 1,0,1,0… for 16 symbols (64 clk), then o_state=2.
- In RUN, upstream supplies 2'b10, 2'b01, 2'b11 with valid always 1 → o_sym_ready pulses once per 4 clk. o_tx_i/q = (1,0),(0,1),(1,1) starting at phase 0 after each accepting strobe.
- In RUN, i_sym_valid=0 for 3 symbol periods → alternating idle bits emitted, o_underflow_cnt=3, o_state stays 2.
- i_enable drops mid-RUN → at the next strobe o_state=3, exactly 6 alternating symbols (24 clk), then o_state=0, o_busy=0, o_phase=0.
- rst asserted asynchronously mid-PREAMBLE (between clk edges) → outputs reach reset values before the next edge. i_enable=1 after release restarts a full 16-symbol preamble.
- With QPSK_TX_PRBS_EN defined and i_prbs_mode=1 → the first 9 I bits in RUN match the PRBS9 reference sequence from seed 9'h1AA, and o_underflow_cnt stays 0.
